// File: rtl/apb_wait_completer_if.sv
// APB bus bundle between the bridge (master) and the wait-state completer (slave).
interface apb_wait_completer_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_wait_completer.sv
// APB completer with a small byte register file, a programmable wait-state
// count held in a control register, and PSLVERR for unmapped addresses.
//
// state  | meaning
// IDLE   | no transfer in flight, waiting for a setup phase
// ACCESS | transfer latched, counting wait cycles down to PREADY
module apb_wait_completer #(
  parameter int         DEPTH      = 64,
  parameter logic [7:0] CTRL_ADDR  = 8'hFF,
  parameter int         RESET_WAIT = 2
) (
  input logic                  PCLK,
  input logic                  PRESET,
  apb_wait_completer_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state;
  logic [2:0]      wcnt;
  logic [2:0]      wait_cfg;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [7:0]      wdata_q;
  logic            err_q;
  logic            ctrl_q;
  logic [7:0]      rdata_q;
  logic [7:0]      mem [DEPTH];

  logic            setup;
  logic            hit_mem;
  logic            hit_ctrl;
  logic [7:0]      setup_rdata;
  logic            pready;

  // Setup-phase address decode and read-data precompute; the control register
  // wins if it ever overlaps the storage range.
  always_comb begin
    setup       = bus.PSEL & ~bus.PENABLE;
    hit_ctrl    = (bus.PADDR == CTRL_ADDR);
    hit_mem     = ({1'b0, bus.PADDR} < 9'(DEPTH)) & ~hit_ctrl;
    setup_rdata = 8'h00;
    if (hit_ctrl)
      setup_rdata = {5'b0, wait_cfg};
    else if (hit_mem)
      setup_rdata = mem[bus.PADDR[AW-1:0]];
  end

  assign pready      = (state == ACCESS) && (wcnt == 3'd0) && bus.PSEL && bus.PENABLE;
  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pready & err_q;
  assign bus.PRDATA  = rdata_q;

  // Transfer FSM: a setup phase always (re)latches, even mid-transfer, since
  // it can only appear in ACCESS when the bridge has abandoned the transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      wcnt     <= 3'd0;
      wait_cfg <= 3'(RESET_WAIT);
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= 8'h00;
      err_q    <= 1'b0;
      ctrl_q   <= 1'b0;
      rdata_q  <= 8'h00;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
    end else if (setup) begin
      state   <= ACCESS;
      addr_q  <= bus.PADDR[AW-1:0];
      write_q <= bus.PWRITE;
      wdata_q <= bus.PWDATA;
      err_q   <= ~(hit_mem | hit_ctrl);
      ctrl_q  <= hit_ctrl;
      wcnt    <= wait_cfg;
      rdata_q <= setup_rdata;
    end else if (state == ACCESS) begin
      if (bus.PSEL && bus.PENABLE) begin
        if (wcnt != 3'd0) begin
          wcnt <= wcnt - 3'd1;
        end else begin
          state <= IDLE;
          if (write_q && !err_q) begin
            if (ctrl_q)
              wait_cfg <= wdata_q[2:0];
            else
              mem[addr_q] <= wdata_q;
          end
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: doc/apb_wait_completer.md
# apb_wait_completer

APB completer (responder) with an internal 8-bit register file, a programmable wait-state count and error signalling for unmapped addresses. It sits on the peripheral side of the APB bus, selected by one PSELx line from the bridge, and drives PRDATA/PREADY/PSLVERR back to the bridge mux. It is the bench's controllable far-end target for wait-state and error-path coverage of the bridge.

## Interface
- DEPTH, 64: number of 8-bit storage locations, mapped at PADDR 0..DEPTH-1 (DEPTH ≤ 255)
- CTRL_ADDR, 8'hFF: address of the wait-count control register
- RESET_WAIT, 2: reset value of the wait-count register (0..7)
- PCLK  input  1  bus clock; all state updates on rising edge
- PRESET  input  1  synchronous, active-high reset
- PSEL  input  1  completer select
- PENABLE  input  1  access-phase indicator
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  8  byte address
- PWDATA  input  8  write data
- PRDATA  output  8  read data; valid only while PREADY=1 on a read
- PREADY  output  1  transfer completes in this cycle
- PSLVERR  output  1  error response; valid only while PREADY=1

## Operation
- Storage: DEPTH×8 array `mem`, plus `wait_cfg[2:0]` at CTRL_ADDR (reads return {5'b0, wait_cfg}; writes take PWDATA[2:0]).
- Address decode at setup: `hit_mem` = PADDR < DEPTH; `hit_ctrl` = PADDR == CTRL_ADDR; otherwise error.
- FSM states: IDLE, ACCESS.
  - IDLE: on PSEL=1 & PENABLE=0 (setup phase) latch PADDR, PWRITE, PWDATA, error flag; load `wcnt` = wait_cfg; precompute read data into PRDATA register; go ACCESS.
  - ACCESS: if PSEL=1 & PENABLE=1 and `wcnt`≠0, decrement `wcnt`, PREADY=0. If `wcnt`=0, PREADY=1 this cycle; transfer commits on this edge; go IDLE.
  - ACCESS with PSEL=0 or PENABLE=0 (protocol abort): go IDLE, no commit, no write; if PSEL=1 & PENABLE=0 this cycle, treat as a fresh setup (relatch, go ACCESS).
- Commit: write to `mem`/`wait_cfg` only when PREADY=1, PWRITE=1 (latched) and no error. Erroring writes change nothing.
- Read data: PRDATA = mem[addr] or {5'b0,wait_cfg}; erroring reads return 8'h00. PRDATA is held stable across all wait cycles.
- PSLVERR = PREADY & error flag; never high when PREADY=0.
- Writes to CTRL_ADDR affect only subsequent transfers; the current transfer's wait count is already loaded.
- PADDR/PWDATA changes during ACCESS are ignored (latched values used).

## Timing
- Reset (PRESET=1 at a PCLK edge): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=8'h00, wait_cfg=RESET_WAIT, all `mem` entries 8'h00. Reset mid-transfer aborts it with no commit; PREADY never asserts in the cycle after reset.
- PREADY combinational from registered state: state==ACCESS & wcnt==0 & PSEL & PENABLE.
- Latency: first access cycle is the cycle after setup. With wait_cfg=N, PREADY rises in the (N+1)-th access cycle; total transfer = N+2 cycles.
- Back-to-back: a setup phase in the cycle immediately after the PREADY cycle is accepted (IDLE sees it); no dead cycle required.
- Write visible to a read whose setup phase is the cycle after the write's PREADY cycle.
- PSEL=0 in IDLE: outputs PREADY=0, PSLVERR=0, PRDATA holds last value.

## Test plan
- Reset then read addr 8'h05 with default wait -> PREADY high on 3rd access cycle... i.e. 2 wait cycles then PREADY=1, PRDATA=8'h00, PSLVERR=0; read CTRL_ADDR -> PRDATA=8'h02.
- Write 8'hA5 to 8'h10 with wait_cfg=0, then back-to-back read 8'h10 -> each transfer 2 cycles, PREADY in first access cycle, read returns 8'hA5.
- Write 8'h07 to CTRL_ADDR, then read 8'h3F -> 7 cycles PREADY=0 in access, PRDATA stable throughout, PREADY=1 on 8th access cycle.
- Write 8'h55 to 8'h40 (DEPTH=64) -> PREADY=1 with PSLVERR=1; subsequent read 8'h40 -> PSLVERR=1, PRDATA=8'h00; mem unchanged (read 8'h00 still 8'h00).
- Write to 8'h20 with wait_cfg=3, drop PENABLE after 1 wait cycle -> no PREADY, read 8'h20 returns old value 8'h00.
- Assert PRESET during wait cycle of a write to CTRL_ADDR (data 8'h00) -> PREADY stays 0, wait_cfg reads back 8'h02 afterwards.
